// File: rtl/vc_dest_arbiter_pkg.sv
// Shared types and defaults for the VC-to-destination arbiter slice.
package vc_dest_arbiter_pkg;

  localparam int unsigned DATA_W    = 6;
  localparam int unsigned DEST_BIT  = 4;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned BURST_W   = 3;

  typedef enum logic [1:0] {
    ST_INACTIVE = 2'd0,
    ST_RUN      = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  typedef logic [DATA_W-1:0] word_t;

  // Pop tracking for the first pipeline stage.
  typedef struct packed {
    logic valid;
    logic src;
  } stage1_t;

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Bundle of VC FIFO, destination FIFO and control signals around the arbiter.
interface vc_dest_arbiter_if
  import vc_dest_arbiter_pkg::*;
  ;
  logic               active_in;
  logic               vc0_empty;
  logic               vc1_empty;
  word_t              vc0_data;
  word_t              vc1_data;
  logic               d0_af;
  logic               d1_af;
  logic               vc0_pop;
  logic               vc1_pop;
  logic               d0_push;
  logic               d1_push;
  word_t              data_out;
  logic               idle_out;
  logic [BURST_W-1:0] burst_cnt;

  modport slave (
    input  active_in, vc0_empty, vc1_empty, vc0_data, vc1_data, d0_af, d1_af,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out, idle_out, burst_cnt
  );

  modport master (
    output active_in, vc0_empty, vc1_empty, vc0_data, vc1_data, d0_af, d1_af,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out, idle_out, burst_cnt
  );

endinterface

// File: rtl/vc_dest_arbiter_prio_sel.sv
// VC0-priority grant logic with a burst counter that lets VC1 through
// after MAX_BURST consecutive VC0 grants.
module vc_dest_arbiter_prio_sel
  import vc_dest_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = vc_dest_arbiter_pkg::MAX_BURST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               vc0_empty,
  input  logic               vc1_empty,
  output logic               vc0_gnt,
  output logic               vc1_gnt,
  output logic [BURST_W-1:0] burst_cnt
);

  logic at_limit;

  assign at_limit = (burst_cnt == BURST_W'(MAX_BURST));

  always_comb begin
    vc1_gnt = 1'b0;
    vc0_gnt = 1'b0;
    vc1_gnt = en & ~vc1_empty & (vc0_empty | at_limit);
    vc0_gnt = en & ~vc0_empty & ~vc1_gnt;
  end

  // Count only VC0 grants that made VC1 wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (vc1_gnt) begin
      burst_cnt <= '0;
    end else if (vc0_gnt) begin
      if (vc1_empty)      burst_cnt <= '0;
      else if (!at_limit) burst_cnt <= burst_cnt + BURST_W'(1);
    end
  end

endmodule

// File: rtl/vc_dest_arbiter.sv
// Moves words from VC0/VC1 FIFOs into D0/D1 FIFOs through a 2-stage pipeline,
// gated by destination almost-full and the active flag.
module vc_dest_arbiter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int unsigned DEST_BIT  = vc_dest_arbiter_pkg::DEST_BIT,
  parameter int unsigned MAX_BURST = vc_dest_arbiter_pkg::MAX_BURST
) (
  input logic              clk,
  input logic              reset,
  vc_dest_arbiter_if.slave bus
);

  state_t             state;
  stage1_t            s1;
  word_t              sel_data;
  word_t              data_q;
  logic               d0_q;
  logic               d1_q;
  logic               af;
  logic               en;
  logic               vc0_gnt;
  logic               vc1_gnt;
  logic [BURST_W-1:0] burst;

  assign af = bus.d0_af | bus.d1_af;
  assign en = (state == ST_RUN) & ~af;

  vc_dest_arbiter_prio_sel #(
    .MAX_BURST (MAX_BURST)
  ) u_prio_sel (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .vc0_empty (bus.vc0_empty),
    .vc1_empty (bus.vc1_empty),
    .vc0_gnt   (vc0_gnt),
    .vc1_gnt   (vc1_gnt),
    .burst_cnt (burst)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INACTIVE;
    end else begin
      case (state)
        ST_INACTIVE: if (bus.active_in) state <= ST_RUN;
        ST_RUN: begin
          if (!bus.active_in) state <= ST_INACTIVE;
          else if (af)        state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!bus.active_in) state <= ST_INACTIVE;
          else if (!af)       state <= ST_RUN;
        end
        default: state <= ST_INACTIVE;
      endcase
    end
  end

  // VC read data arrives the cycle after the pop, steered by the stage-1 source.
  assign sel_data = s1.src ? bus.vc1_data : bus.vc0_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      data_q <= '0;
      d0_q   <= 1'b0;
      d1_q   <= 1'b0;
    end else begin
      s1.valid <= vc0_gnt | vc1_gnt;
      s1.src   <= vc1_gnt;
      d0_q     <= s1.valid & ~sel_data[DEST_BIT];
      d1_q     <= s1.valid &  sel_data[DEST_BIT];
      if (s1.valid) data_q <= sel_data;
    end
  end

  assign bus.vc0_pop   = vc0_gnt;
  assign bus.vc1_pop   = vc1_gnt;
  assign bus.d0_push   = d0_q;
  assign bus.d1_push   = d1_q;
  assign bus.data_out  = data_q;
  assign bus.burst_cnt = burst;
  assign bus.idle_out  = bus.vc0_empty & bus.vc1_empty & ~s1.valid & ~(d0_q | d1_q);

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter: VC FIFO models feed the DUT, a monitor logs pushes.
module tb_vc_dest_arbiter;
  import vc_dest_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vc_dest_arbiter_if bus ();

  vc_dest_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // VC FIFO models: read data appears the cycle after the pop
  word_t vc0_mem [64];
  word_t vc1_mem [64];
  int    vc0_wr = 0, vc0_rd = 0, vc1_wr = 0, vc1_rd = 0;
  word_t vc0_q = '0, vc1_q = '0;
  int    pop_err = 0;

  assign bus.vc0_empty = (vc0_rd == vc0_wr);
  assign bus.vc1_empty = (vc1_rd == vc1_wr);
  assign bus.vc0_data  = vc0_q;
  assign bus.vc1_data  = vc1_q;

  always @(posedge clk) begin
    if (bus.vc0_pop && vc0_rd != vc0_wr) begin
      vc0_q  <= vc0_mem[vc0_rd];
      vc0_rd <= vc0_rd + 1;
    end
    if (bus.vc1_pop && vc1_rd != vc1_wr) begin
      vc1_q  <= vc1_mem[vc1_rd];
      vc1_rd <= vc1_rd + 1;
    end
    if ((bus.vc0_pop && vc0_rd == vc0_wr) || (bus.vc1_pop && vc1_rd == vc1_wr) ||
        (bus.vc0_pop && bus.vc1_pop))
      pop_err <= pop_err + 1;
  end

  // Destination push log
  word_t log_val [64];
  logic  log_dst [64];
  int    log_n    = 0;
  int    both_err = 0;

  always @(posedge clk) begin
    if (bus.d0_push && bus.d1_push) both_err <= both_err + 1;
    if (bus.d0_push || bus.d1_push) begin
      log_val[log_n] <= bus.data_out;
      log_dst[log_n] <= bus.d1_push;
      log_n          <= log_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input word_t w);
    vc0_mem[vc0_wr] = w;
    vc0_wr = vc0_wr + 1;
  endtask

  task automatic load1(input word_t w);
    vc1_mem[vc1_wr] = w;
    vc1_wr = vc1_wr + 1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.idle_out && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.idle_out), 32'd1);
  endtask

  int exp_g1    [10];
  int exp_b     [10];
  int exp_order [20];
  int exp_c     [4];
  int base;

  initial begin
    exp_g1    = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    exp_b     = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    exp_order = '{0, 1, 2, 3, 16, 4, 5, 6, 7, 17, 8, 9, 18, 19, 20, 21, 22, 23, 24, 25};
    exp_c     = '{1, 2, 3, 4};

    bus.active_in = 1'b0;
    bus.d0_af     = 1'b0;
    bus.d1_af     = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_state",  32'(dut.state),     32'(ST_INACTIVE));
    check("rst_pop0",   32'(bus.vc0_pop),   32'd0);
    check("rst_pop1",   32'(bus.vc1_pop),   32'd0);
    check("rst_push0",  32'(bus.d0_push),   32'd0);
    check("rst_push1",  32'(bus.d1_push),   32'd0);
    check("rst_data",   32'(bus.data_out),  32'd0);
    check("rst_burst",  32'(bus.burst_cnt), 32'd0);
    check("rst_idle",   32'(bus.idle_out),  32'd1);
    reset = 1'b0;
    tick();

    // Single VC0 stream, destinations alternate by bit 4
    load0(6'h05); load0(6'h15); load0(6'h25);
    #1;
    check("a_inact_pop", 32'(bus.vc0_pop),  32'd0);
    check("a_inact_idle",32'(bus.idle_out), 32'd0);
    bus.active_in = 1'b1;
    tick(); // cycle 0
    check("a_c0_pop0", 32'(bus.vc0_pop), 32'd1);
    check("a_c0_pop1", 32'(bus.vc1_pop), 32'd0);
    tick(); // cycle 1
    check("a_c1_pop0", 32'(bus.vc0_pop), 32'd1);
    tick(); // cycle 2
    check("a_c2_pop0",  32'(bus.vc0_pop),  32'd1);
    check("a_c2_push0", 32'(bus.d0_push),  32'd1);
    check("a_c2_push1", 32'(bus.d1_push),  32'd0);
    check("a_c2_data",  32'(bus.data_out), 32'h05);
    tick(); // cycle 3
    check("a_c3_pop0",  32'(bus.vc0_pop),  32'd0);
    check("a_c3_push0", 32'(bus.d0_push),  32'd0);
    check("a_c3_push1", 32'(bus.d1_push),  32'd1);
    check("a_c3_data",  32'(bus.data_out), 32'h15);
    tick(); // cycle 4
    check("a_c4_push0", 32'(bus.d0_push),  32'd1);
    check("a_c4_data",  32'(bus.data_out), 32'h25);
    check("a_c4_idle",  32'(bus.idle_out), 32'd0);
    tick(); // cycle 5
    check("a_c5_idle",  32'(bus.idle_out), 32'd1);
    check("a_c5_push0", 32'(bus.d0_push),  32'd0);
    check("a_c5_burst", 32'(bus.burst_cnt),32'd0);

    // Both VCs loaded: VC0 x4 then VC1 while both are non-empty
    base = log_n;
    for (int i = 0; i < 10; i++) begin
      load0(6'(i));
      load1(6'(16 + i));
    end
    #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("b_g0_%0d", i), 32'(bus.vc0_pop),   32'(1 - exp_g1[i]));
      check($sformatf("b_g1_%0d", i), 32'(bus.vc1_pop),   32'(exp_g1[i]));
      check($sformatf("b_bc_%0d", i), 32'(bus.burst_cnt), 32'(exp_b[i]));
      tick();
    end
    wait_idle("b_idle", 60);
    check("b_count", 32'(log_n - base), 32'd20);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("b_val_%0d", k), 32'(log_val[base + k]), 32'(exp_order[k]));
      check($sformatf("b_dst_%0d", k), 32'(log_dst[base + k]), 32'(exp_order[k] >= 16));
    end

    // Almost-full after two pops: in-flight words still drain
    base = log_n;
    load0(6'h01); load0(6'h02); load0(6'h03); load0(6'h04);
    #1;
    check("c_c0_pop", 32'(bus.vc0_pop), 32'd1);
    tick();
    check("c_c1_pop", 32'(bus.vc0_pop), 32'd1);
    tick();
    bus.d1_af = 1'b1;
    #1;
    check("c_c2_pop",   32'(bus.vc0_pop),  32'd0);
    check("c_c2_push0", 32'(bus.d0_push),  32'd1);
    check("c_c2_data",  32'(bus.data_out), 32'h01);
    tick();
    check("c_c3_state", 32'(dut.state),    32'(ST_HOLD));
    check("c_c3_pop",   32'(bus.vc0_pop),  32'd0);
    check("c_c3_push0", 32'(bus.d0_push),  32'd1);
    check("c_c3_data",  32'(bus.data_out), 32'h02);
    tick();
    check("c_c4_pop",   32'(bus.vc0_pop),  32'd0);
    check("c_c4_push0", 32'(bus.d0_push),  32'd0);
    tick();
    bus.d1_af = 1'b0;
    #1;
    check("c_c5_state", 32'(dut.state),   32'(ST_HOLD));
    check("c_c5_pop",   32'(bus.vc0_pop), 32'd0);
    tick();
    check("c_c6_state", 32'(dut.state),   32'(ST_RUN));
    check("c_c6_pop",   32'(bus.vc0_pop), 32'd1);
    wait_idle("c_idle", 30);
    check("c_count", 32'(log_n - base), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("c_val_%0d", k), 32'(log_val[base + k]), 32'(exp_c[k]));

    // active_in drops while streaming
    base = log_n;
    load0(6'h30); load0(6'h31); load0(6'h32); load0(6'h33);
    #1;
    check("d_c0_pop", 32'(bus.vc0_pop), 32'd1);
    tick();
    bus.active_in = 1'b0;
    #1;
    check("d_c1_pop", 32'(bus.vc0_pop), 32'd1);
    tick();
    check("d_c2_state", 32'(dut.state),    32'(ST_INACTIVE));
    check("d_c2_pop",   32'(bus.vc0_pop),  32'd0);
    check("d_c2_push1", 32'(bus.d1_push),  32'd1);
    check("d_c2_data",  32'(bus.data_out), 32'h30);
    tick();
    check("d_c3_push1", 32'(bus.d1_push),  32'd1);
    check("d_c3_data",  32'(bus.data_out), 32'h31);
    tick();
    check("d_c4_push1", 32'(bus.d1_push),  32'd0);
    repeat (5) tick();
    check("d_hold_pop",   32'(bus.vc0_pop),   32'd0);
    check("d_hold_empty", 32'(bus.vc0_empty), 32'd0);
    check("d_hold_idle",  32'(bus.idle_out),  32'd0);
    check("d_count",      32'(log_n - base),  32'd2);
    check("d_val_0",      32'(log_val[base]),     32'h30);
    check("d_val_1",      32'(log_val[base + 1]), 32'h31);

    // Reset with two words in flight
    base = log_n;
    bus.active_in = 1'b1;
    #1;
    check("e_e0_pop", 32'(bus.vc0_pop), 32'd0);
    tick();
    check("e_e1_pop", 32'(bus.vc0_pop), 32'd1);
    tick();
    check("e_e2_pop", 32'(bus.vc0_pop), 32'd1);
    tick();
    check("e_e3_push1", 32'(bus.d1_push), 32'd1);
    reset = 1'b1;
    bus.active_in = 1'b0;
    #1;
    check("e_rst_state", 32'(dut.state),     32'(ST_INACTIVE));
    check("e_rst_push0", 32'(bus.d0_push),   32'd0);
    check("e_rst_push1", 32'(bus.d1_push),   32'd0);
    check("e_rst_pop0",  32'(bus.vc0_pop),   32'd0);
    check("e_rst_data",  32'(bus.data_out),  32'd0);
    check("e_rst_burst", 32'(bus.burst_cnt), 32'd0);
    check("e_rst_idle",  32'(bus.idle_out),  32'd1);
    tick(); tick();
    reset = 1'b0;
    repeat (4) tick();
    check("e_dropped", 32'(log_n - base),  32'd0);
    check("e_idle",    32'(bus.idle_out),  32'd1);

    check("both_push", 32'(both_err), 32'd0);
    check("pop_err",   32'(pop_err),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
